// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS entry/countdown chain.
package timer_pkg;
  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

  localparam int BCD_UNITS_MAX = 9;
  localparam int BCD_TENS_MAX  = 5;
  localparam int KEY_DIGIT_MAX = 9;

  typedef logic [3:0] bcd_t;
endpackage

// File: rtl/timer_entry_loader_if.sv
// Keypad strobes in, preset digits and counter controls out.
interface timer_entry_loader_if;
  import timer_pkg::*;

  logic       key_valid;
  bcd_t       key_code;
  logic       key_clear;
  logic       key_start;
  logic       timer_zero;
  bcd_t       min_tens;
  bcd_t       min_ones;
  bcd_t       sec_tens;
  bcd_t       sec_ones;
  logic       loadn;
  logic       count_en;
  logic [2:0] entry_cnt;
  logic       busy;

  modport master (
    output key_valid, key_code, key_clear, key_start, timer_zero,
    input  min_tens, min_ones, sec_tens, sec_ones, loadn, count_en, entry_cnt, busy
  );

  modport slave (
    input  key_valid, key_code, key_clear, key_start, timer_zero,
    output min_tens, min_ones, sec_tens, sec_ones, loadn, count_en, entry_cnt, busy
  );
endinterface

// File: rtl/bcd_entry_shift_reg.sv
// Four BCD preset digits; new digits enter at sec_ones and push left.
module bcd_entry_shift_reg
  import timer_pkg::*;
#(
  parameter int SEC_TENS_MAX = BCD_TENS_MAX
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr,
  input  logic shift,
  input  logic clamp,
  input  bcd_t din,
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones
);
  localparam bcd_t TENS_LIM  = bcd_t'(SEC_TENS_MAX);
  localparam bcd_t UNITS_LIM = bcd_t'(BCD_UNITS_MAX);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (clr) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (clamp) begin
      // Out-of-range seconds saturate to 59; minutes pass through untouched.
      if (sec_tens > TENS_LIM) begin
        sec_tens <= TENS_LIM;
        sec_ones <= UNITS_LIM;
      end
    end else if (shift) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= din;
    end
  end
endmodule

// File: rtl/timer_entry_loader.sv
// Keypad entry FSM: collects MM:SS digits, issues a one-cycle load, then enables countdown.
module timer_entry_loader
  import timer_pkg::*;
#(
  parameter int MAX_DIGITS   = 4,
  parameter int SEC_TENS_MAX = BCD_TENS_MAX
) (
  input logic                 clk,
  input logic                 clrn,
  timer_entry_loader_if.slave bus
);
  state_t     state, state_nx;
  logic [2:0] entry_cnt;
  logic       do_clr, do_shift, do_clamp;
  logic       key_is_digit, all_zero, room;
  logic       loadn, count_en, busy;
  bcd_t       min_tens, min_ones, sec_tens, sec_ones;

  assign key_is_digit = bus.key_code <= bcd_t'(KEY_DIGIT_MAX);
  assign all_zero     = ({min_tens, min_ones, sec_tens, sec_ones} == '0);
  assign room         = entry_cnt < 3'(MAX_DIGITS);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_clr   = 1'b0;
    do_shift = 1'b0;
    do_clamp = 1'b0;
    if (bus.key_clear) begin
      do_clr   = 1'b1;
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, ENTRY: begin
          // A Start strobe owns the cycle even when it is ignored.
          if (bus.key_start) begin
            if (state == ENTRY && !all_zero) begin
              do_clamp = 1'b1;
              state_nx = LOAD;
            end
          end else if (bus.key_valid && key_is_digit && room) begin
            do_shift = 1'b1;
            state_nx = ENTRY;
          end
        end
        LOAD: state_nx = RUN;
        RUN: begin
          if (bus.timer_zero) begin
            do_clr   = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      entry_cnt <= '0;
      loadn     <= 1'b1;
      count_en  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (do_clr)        entry_cnt <= '0;
      else if (do_shift) entry_cnt <= entry_cnt + 3'd1;
      // Controls follow the next state so they change on the same edge as it.
      loadn    <= (state_nx != LOAD);
      count_en <= (state_nx == RUN);
      busy     <= (state_nx == LOAD) || (state_nx == RUN);
    end
  end

  bcd_entry_shift_reg #(.SEC_TENS_MAX(SEC_TENS_MAX)) u_digits (
    .clk      (clk),
    .clrn     (clrn),
    .clr      (do_clr),
    .shift    (do_shift),
    .clamp    (do_clamp),
    .din      (bus.key_code),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones)
  );

  assign bus.min_tens  = min_tens;
  assign bus.min_ones  = min_ones;
  assign bus.sec_tens  = sec_tens;
  assign bus.sec_ones  = sec_ones;
  assign bus.entry_cnt = entry_cnt;
  assign bus.loadn     = loadn;
  assign bus.count_en  = count_en;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_timer_entry_loader.sv
// Directed plan steps followed by random keypad traffic, checked against a digit-list model.
module tb_timer_entry_loader;
  import timer_pkg::*;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  timer_entry_loader_if bus ();
  timer_entry_loader dut (.clk(clk), .clrn(clrn), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: digit list oldest-first (md[0]=min_tens), digit count, and phase.
  int md[4];
  int mcnt;
  int mphase;  // 0 idle, 1 entering, 2 loading, 3 running

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) md[i] = 0;
    mcnt   = 0;
    mphase = 0;
  endtask

  task automatic model_step(input bit v, input int code, input bit c, input bit s, input bit tz);
    if (c) model_clear();
    else if (mphase == 2) mphase = 3;
    else if (mphase == 3) begin
      if (tz) model_clear();
    end else if (s) begin
      if (mphase == 1 && (md[0] + md[1] + md[2] + md[3]) != 0) begin
        if (md[2] > 5) begin md[2] = 5; md[3] = 9; end
        mphase = 2;
      end
    end else if (v && code <= 9 && mcnt < 4) begin
      md[0] = md[1]; md[1] = md[2]; md[2] = md[3]; md[3] = code;
      mcnt++;
      mphase = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".min_tens"},  32'(bus.min_tens),  32'(md[0]));
    chk({tag, ".min_ones"},  32'(bus.min_ones),  32'(md[1]));
    chk({tag, ".sec_tens"},  32'(bus.sec_tens),  32'(md[2]));
    chk({tag, ".sec_ones"},  32'(bus.sec_ones),  32'(md[3]));
    chk({tag, ".entry_cnt"}, 32'(bus.entry_cnt), 32'(mcnt));
    chk({tag, ".loadn"},     32'(bus.loadn),     32'(mphase != 2));
    chk({tag, ".count_en"},  32'(bus.count_en),  32'(mphase == 3));
    chk({tag, ".busy"},      32'(bus.busy),      32'(mphase >= 2));
  endtask

  // Drive one cycle of inputs from a negedge, advance, then check at the next negedge.
  task automatic step(input string tag, input bit v, input int code, input bit c, input bit s, input bit tz);
    bus.key_valid  = v;
    bus.key_code   = 4'(code);
    bus.key_clear  = c;
    bus.key_start  = s;
    bus.timer_zero = tz;
    @(posedge clk);
    model_step(v, code, c, s, tz);
    @(negedge clk);
    bus.key_valid  = 1'b0;
    bus.key_clear  = 1'b0;
    bus.key_start  = 1'b0;
    bus.timer_zero = 1'b0;
    check_all(tag);
  endtask

  task automatic key(input string tag, input int code);
    step(tag, 1'b1, code, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.key_valid = 1'b0; bus.key_code = '0; bus.key_clear = 1'b0;
    bus.key_start = 1'b0; bus.timer_zero = 1'b0;
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk);
    clrn = 1'b1;

    // 1,3,0 then Start: one-cycle load of 01:30, then run until zero.
    key("k1", 1); key("k3", 3); key("k0", 0);
    chk("e130.cnt", 32'(bus.entry_cnt), 32'd3);
    step("start130", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("e130.loadn_low", 32'(bus.loadn), 32'd0);
    chk("e130.sec_tens", 32'(bus.sec_tens), 32'd3);
    idle("run130");
    chk("e130.count_en", 32'(bus.count_en), 32'd1);
    idle("run130b");
    step("zero130", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("e130.idle_cnt", 32'(bus.entry_cnt), 32'd0);

    // 9999 plus an ignored fifth digit; seconds clamp to 59 on Start.
    key("k9a", 9); key("k9b", 9); key("k9c", 9); key("k9d", 9); key("k7x", 7);
    chk("e9999.cnt", 32'(bus.entry_cnt), 32'd4);
    step("start9999", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("e9999.sec_tens", 32'(bus.sec_tens), 32'd5);
    chk("e9999.sec_ones", 32'(bus.sec_ones), 32'd9);
    chk("e9999.min_tens", 32'(bus.min_tens), 32'd9);
    idle("run9999"); idle("run9999b");

    // Asynchronous reset in the middle of RUN.
    #2 clrn = 1'b0;
    #1 model_clear();
    check_all("async_rst");
    @(negedge clk);
    clrn = 1'b1;

    // Non-digit codes and Start in IDLE do nothing; all-zero entry refuses Start.
    key("k12a", 12); key("k12b", 12);
    step("start_idle", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    key("k0a", 0); key("k0b", 0);
    step("start_zero", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("zero.loadn", 32'(bus.loadn), 32'd1);
    idle("zero_hold");

    // Clear, Start and a digit together: Clear wins.
    key("k5pre", 5);
    step("clr_all", 1'b1, 5, 1'b1, 1'b1, 1'b0);
    chk("clr_all.cnt", 32'(bus.entry_cnt), 32'd0);

    // Keys and Start during RUN are ignored; Clear aborts the countdown.
    key("k2", 2); key("k4", 4);
    step("start24", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle("run24");
    key("k7run", 7);
    step("start_run", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("run.loadn", 32'(bus.loadn), 32'd1);
    step("clr_run", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("clr_run.count_en", 32'(bus.count_en), 32'd0);

    // Random keypad traffic.
    for (int n = 0; n < 800; n++) begin
      step("rand",
           ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
